// File: rtl/vend_core_param.sv
// vend_core_param: vending-machine transaction core on the 1 Hz enable clock.
// Accumulates coin credit, latches a product selection, and pulses a one-hot
// vend output. The remainder after a vend is either kept as credit or offered
// as change.
// Optional feature macro: VEND_CHANGE_EN. When it is defined, cancel is
// honoured and a nonzero remainder is paid out through change/change_valid.
// When it is not defined, cancel is ignored and change/change_valid stay 0.
module vend_core_param #(
    parameter int                   W           = 8,
    parameter int                   N_COINS     = 3,
    parameter logic [N_COINS*W-1:0] COIN_VALUES = {8'd25, 8'd10, 8'd5},
    parameter int                   N_ITEMS     = 4,
    parameter logic [N_ITEMS*W-1:0] PRICES      = {8'd30, 8'd25, 8'd20, 8'd15},
    parameter int                   MAX_CREDIT  = 35
) (
    input  logic               clk_1Hz,
    input  logic               clr,
    input  logic [N_COINS-1:0] coin,
    input  logic [N_ITEMS-1:0] sel,
    input  logic               cancel,
    input  logic               change_ack,
    output logic [W-1:0]       credit,
    output logic [W-1:0]       price,
    output logic [N_ITEMS-1:0] vend,
    output logic [N_ITEMS-1:0] led,
    output logic               coin_reject,
    output logic [W-1:0]       change,
    output logic               change_valid
);

    localparam int         SEL_W = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;
    localparam logic [W:0] MAX_C = (W+1)'(MAX_CREDIT);

`ifdef VEND_CHANGE_EN
    localparam bit CHANGE_EN = 1'b1;
`else
    localparam bit CHANGE_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ACCUM, VEND, CHANGE} state_t;

    state_t             state_reg, state_next;
    logic [W-1:0]       credit_reg, credit_next;
    logic [SEL_W-1:0]   sel_idx_reg, sel_idx_next;
    logic               sel_valid_reg, sel_valid_next;
    logic [N_ITEMS-1:0] vend_reg, vend_next;
    logic [N_ITEMS-1:0] led_reg, led_next;
    logic               coin_reject_reg, coin_reject_next;
    logic [W-1:0]       change_reg, change_next;
    logic               change_valid_reg, change_valid_next;

    // Unpacked lookup tables for coin values and item prices.
    logic [W-1:0] coin_tab  [N_COINS];
    logic [W-1:0] price_tab [N_ITEMS];

    generate
        for (genvar gi = 0; gi < N_COINS; gi++) begin : g_coin_tab
            assign coin_tab[gi] = COIN_VALUES[gi*W +: W];
        end
        for (genvar gi = 0; gi < N_ITEMS; gi++) begin : g_price_tab
            assign price_tab[gi] = PRICES[gi*W +: W];
        end
    endgenerate

    logic             coin_hit;
    logic [W-1:0]     coin_val;
    logic             sel_hit;
    logic [SEL_W-1:0] sel_new_idx;
    logic [W:0]       coin_sum;
    logic             coin_fits;
    logic [W-1:0]     price_cur;
    logic             affordable;
    logic             cancel_act;
    logic [N_ITEMS-1:0] vend_onehot;

    // Priority-pick the lowest-index coin; higher simultaneous coins are dropped.
    always_comb begin
        coin_hit = 1'b0;
        coin_val = '0;
        for (int i = N_COINS - 1; i >= 0; i--) begin
            if (coin[i]) begin
                coin_hit = 1'b1;
                coin_val = coin_tab[i];
            end
        end
    end

    // Priority-pick the lowest-index selection bit.
    always_comb begin
        sel_hit     = 1'b0;
        sel_new_idx = '0;
        for (int i = N_ITEMS - 1; i >= 0; i--) begin
            if (sel[i]) begin
                sel_hit     = 1'b1;
                sel_new_idx = SEL_W'(i);
            end
        end
    end

    // One-hot form of the latched selection, used for vend and led.
    always_comb begin
        vend_onehot = '0;
        for (int i = 0; i < N_ITEMS; i++) begin
            vend_onehot[i] = (sel_idx_reg == SEL_W'(i));
        end
    end

    // One extra bit on the sum so the ceiling test cannot wrap.
    assign coin_sum   = {1'b0, credit_reg} + {1'b0, coin_val};
    assign coin_fits  = (coin_sum <= MAX_C);
    assign price_cur  = sel_valid_reg ? price_tab[sel_idx_reg] : '0;
    assign affordable = sel_valid_reg && (credit_reg >= price_cur);
    assign cancel_act = CHANGE_EN && cancel;

    // Next-state and registered-output logic for the transaction FSM.
    always_comb begin
        state_next        = state_reg;
        credit_next       = credit_reg;
        sel_idx_next      = sel_idx_reg;
        sel_valid_next    = sel_valid_reg;
        vend_next         = '0;
        led_next          = led_reg;
        coin_reject_next  = 1'b0;
        change_next       = change_reg;
        change_valid_next = change_valid_reg;

        // Selection is only captured while the machine is taking input.
        if ((state_reg == IDLE || state_reg == ACCUM) && sel_hit) begin
            sel_idx_next   = sel_new_idx;
            sel_valid_next = 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (coin_hit) begin
                    if (coin_fits) begin
                        credit_next = coin_sum[W-1:0];
                        led_next    = '0;
                        state_next  = ACCUM;
                    end else begin
                        coin_reject_next = 1'b1;
                    end
                end
            end
            ACCUM: begin
                if (cancel_act) begin
                    change_next       = credit_reg;
                    change_valid_next = 1'b1;
                    credit_next       = '0;
                    sel_valid_next    = 1'b0;
                    state_next        = CHANGE;
                end else if (affordable) begin
                    // Vend uses the selection held before this edge.
                    credit_next      = credit_reg - price_cur;
                    vend_next        = vend_onehot;
                    led_next         = vend_onehot;
                    coin_reject_next = coin_hit;
                    state_next       = VEND;
                end else if (coin_hit) begin
                    if (coin_fits) begin
                        credit_next = coin_sum[W-1:0];
                        led_next    = '0;
                    end else begin
                        coin_reject_next = 1'b1;
                    end
                end
            end
            VEND: begin
                // Single dispense cycle; a coin arriving now cannot be credited.
                sel_valid_next   = 1'b0;
                coin_reject_next = coin_hit;
                if (credit_reg == '0) begin
                    state_next = IDLE;
                end else if (CHANGE_EN) begin
                    change_next       = credit_reg;
                    change_valid_next = 1'b1;
                    credit_next       = '0;
                    state_next        = CHANGE;
                end else begin
                    state_next = ACCUM;
                end
            end
            CHANGE: begin
                coin_reject_next = coin_hit;
                if (change_ack) begin
                    change_next       = '0;
                    change_valid_next = 1'b0;
                    state_next        = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and output registers; clr aborts any transaction at once.
    always_ff @(posedge clk_1Hz or posedge clr) begin
        if (clr) begin
            state_reg        <= IDLE;
            credit_reg       <= '0;
            sel_idx_reg      <= '0;
            sel_valid_reg    <= 1'b0;
            vend_reg         <= '0;
            led_reg          <= '0;
            coin_reject_reg  <= 1'b0;
            change_reg       <= '0;
            change_valid_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            credit_reg       <= credit_next;
            sel_idx_reg      <= sel_idx_next;
            sel_valid_reg    <= sel_valid_next;
            vend_reg         <= vend_next;
            led_reg          <= led_next;
            coin_reject_reg  <= coin_reject_next;
            change_reg       <= change_next;
            change_valid_reg <= change_valid_next;
        end
    end

    assign credit      = credit_reg;
    assign price       = price_cur;
    assign vend        = vend_reg;
    assign led         = led_reg;
    assign coin_reject = coin_reject_reg;

`ifdef VEND_CHANGE_EN
    assign change       = change_reg;
    assign change_valid = change_valid_reg;
`else
    assign change       = '0;
    assign change_valid = 1'b0;
`endif

endmodule

// File: tb/tb_vend_core_param.sv
// tb_vend_core_param: scoreboard bench for vend_core_param with default
// parameters. Stimulus pushes hand-computed expected outputs into a queue
// before each clock edge, and a monitor pops and compares them just after the
// edge. Expectations follow VEND_CHANGE_EN when it is defined for the build.
module tb_vend_core_param;

    logic       clk_1Hz = 1'b0;
    logic       clr;
    logic [2:0] coin;
    logic [3:0] sel;
    logic       cancel;
    logic       change_ack;
    logic [7:0] credit;
    logic [7:0] price;
    logic [3:0] vend;
    logic [3:0] led;
    logic       coin_reject;
    logic [7:0] change;
    logic       change_valid;

    typedef struct {
        logic [7:0] credit;
        logic [7:0] price;
        logic [3:0] vend;
        logic [3:0] led;
        logic       rej;
        logic [7:0] change;
        logic       cv;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    vend_core_param dut (
        .clk_1Hz      (clk_1Hz),
        .clr          (clr),
        .coin         (coin),
        .sel          (sel),
        .cancel       (cancel),
        .change_ack   (change_ack),
        .credit       (credit),
        .price        (price),
        .vend         (vend),
        .led          (led),
        .coin_reject  (coin_reject),
        .change       (change),
        .change_valid (change_valid)
    );

    always #5 clk_1Hz = ~clk_1Hz;

    task automatic chk(input string nm, input string fld, input logic [7:0] act, input logic [7:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s.%s got %0d required %0d", nm, fld, act, exp);
        end
    endtask

    // Monitor: compares the DUT against the oldest expectation after each edge.
    always @(posedge clk_1Hz) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            chk(e.name, "credit", credit, e.credit);
            chk(e.name, "price", price, e.price);
            chk(e.name, "vend", {4'b0, vend}, {4'b0, e.vend});
            chk(e.name, "led", {4'b0, led}, {4'b0, e.led});
            chk(e.name, "coin_reject", {7'b0, coin_reject}, {7'b0, e.rej});
            chk(e.name, "change", change, e.change);
            chk(e.name, "change_valid", {7'b0, change_valid}, {7'b0, e.cv});
            $display("vec %-12s credit=%0d price=%0d vend=%b led=%b rej=%b change=%0d cv=%b",
                     e.name, credit, price, vend, led, coin_reject, change, change_valid);
        end
    end

    // Drive one cycle of inputs and queue what the outputs must be after the edge.
    task automatic step(input logic [2:0] c, input logic [3:0] s, input logic cn, input logic ack,
                        input logic [7:0] e_cr, input logic [7:0] e_pr, input logic [3:0] e_v,
                        input logic [3:0] e_l, input logic e_rj, input logic [7:0] e_ch,
                        input logic e_cv, input string nm);
        exp_t e;
        @(negedge clk_1Hz);
        coin       = c;
        sel        = s;
        cancel     = cn;
        change_ack = ack;
        e.credit = e_cr; e.price = e_pr; e.vend = e_v; e.led = e_l;
        e.rej = e_rj; e.change = e_ch; e.cv = e_cv; e.name = nm;
        exp_q.push_back(e);
    endtask

    // Assert clr between edges and check that every output drops immediately.
    task automatic do_reset(input string nm);
        @(negedge clk_1Hz);
        clr = 1'b1; coin = '0; sel = '0; cancel = 1'b0; change_ack = 1'b0;
        #1;
        n_vec++;
        chk(nm, "credit", credit, 8'd0);
        chk(nm, "price", price, 8'd0);
        chk(nm, "vend", {4'b0, vend}, 8'd0);
        chk(nm, "led", {4'b0, led}, 8'd0);
        chk(nm, "coin_reject", {7'b0, coin_reject}, 8'd0);
        chk(nm, "change", change, 8'd0);
        chk(nm, "change_valid", {7'b0, change_valid}, 8'd0);
        $display("vec %-12s all outputs after clr credit=%0d vend=%b led=%b cv=%b",
                 nm, credit, vend, led, change_valid);
        @(negedge clk_1Hz);
        clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        clr = 1'b1; coin = '0; sel = '0; cancel = 1'b0; change_ack = 1'b0;
        #12;
        do_reset("reset");

        // Two dimes then item1 (20): exact-credit vend.
        step(3'b010, 4'b0000, 0, 0, 8'd10, 8'd0,  4'b0000, 4'b0000, 0, 8'd0, 0, "dime_a");
        step(3'b010, 4'b0000, 0, 0, 8'd20, 8'd0,  4'b0000, 4'b0000, 0, 8'd0, 0, "dime_b");
        step(3'b000, 4'b0010, 0, 0, 8'd20, 8'd20, 4'b0000, 4'b0000, 0, 8'd0, 0, "sel_item1");
        step(3'b000, 4'b0000, 0, 0, 8'd0,  8'd20, 4'b0010, 4'b0010, 0, 8'd0, 0, "vend_item1");
        step(3'b000, 4'b0000, 0, 0, 8'd0,  8'd0,  4'b0000, 4'b0010, 0, 8'd0, 0, "idle_item1");

        // Quarter then item0 (15): remainder 10.
        step(3'b100, 4'b0000, 0, 0, 8'd25, 8'd0,  4'b0000, 4'b0000, 0, 8'd0, 0, "quarter");
        step(3'b000, 4'b0001, 0, 0, 8'd25, 8'd15, 4'b0000, 4'b0000, 0, 8'd0, 0, "sel_item0");
        step(3'b000, 4'b0000, 0, 0, 8'd10, 8'd15, 4'b0001, 4'b0001, 0, 8'd0, 0, "vend_item0");
`ifdef VEND_CHANGE_EN
        step(3'b000, 4'b0000, 0, 0, 8'd0,  8'd0,  4'b0000, 4'b0001, 0, 8'd10, 1, "chg_offer");
        step(3'b000, 4'b0000, 0, 0, 8'd0,  8'd0,  4'b0000, 4'b0001, 0, 8'd10, 1, "chg_hold");
        step(3'b000, 4'b0000, 0, 1, 8'd0,  8'd0,  4'b0000, 4'b0001, 0, 8'd0,  0, "chg_ack");
`else
        step(3'b000, 4'b0000, 0, 0, 8'd10, 8'd0,  4'b0000, 4'b0001, 0, 8'd0, 0, "keep_rem");
        step(3'b000, 4'b0000, 1, 0, 8'd10, 8'd0,  4'b0000, 4'b0001, 0, 8'd0, 0, "cancel_ign");
`endif
        do_reset("clr_b");

        // Credit ceiling: 30 + 10 refused, 30 + 5 accepted, 35 + 5 refused.
        step(3'b100, 4'b0000, 0, 0, 8'd25, 8'd0, 4'b0000, 4'b0000, 0, 8'd0, 0, "q_25");
        step(3'b001, 4'b0000, 0, 0, 8'd30, 8'd0, 4'b0000, 4'b0000, 0, 8'd0, 0, "n_30");
        step(3'b010, 4'b0000, 0, 0, 8'd30, 8'd0, 4'b0000, 4'b0000, 1, 8'd0, 0, "rej_dime");
        step(3'b001, 4'b0000, 0, 0, 8'd35, 8'd0, 4'b0000, 4'b0000, 0, 8'd0, 0, "n_35");
        step(3'b001, 4'b0000, 0, 0, 8'd35, 8'd0, 4'b0000, 4'b0000, 1, 8'd0, 0, "rej_full");
        step(3'b000, 4'b0000, 0, 0, 8'd35, 8'd0, 4'b0000, 4'b0000, 0, 8'd0, 0, "rej_end");
        do_reset("clr_c");

        // Simultaneous coins take the lowest index; a new sel overwrites the old.
        step(3'b110, 4'b0000, 0, 0, 8'd10, 8'd0,  4'b0000, 4'b0000, 0, 8'd0, 0, "multi_110");
        step(3'b111, 4'b0000, 0, 0, 8'd15, 8'd0,  4'b0000, 4'b0000, 0, 8'd0, 0, "multi_111");
        step(3'b000, 4'b0100, 0, 0, 8'd15, 8'd25, 4'b0000, 4'b0000, 0, 8'd0, 0, "sel_item2");
        step(3'b000, 4'b0011, 0, 0, 8'd15, 8'd15, 4'b0000, 4'b0000, 0, 8'd0, 0, "sel_ovr");
        step(3'b000, 4'b0000, 0, 0, 8'd0,  8'd15, 4'b0001, 4'b0001, 0, 8'd0, 0, "vend_ovr");
        step(3'b000, 4'b0000, 0, 0, 8'd0,  8'd0,  4'b0000, 4'b0001, 0, 8'd0, 0, "idle_ovr");
        do_reset("clr_d");

        // Cancel with an unaffordable selection pending.
        step(3'b010, 4'b0000, 0, 0, 8'd10, 8'd0,  4'b0000, 4'b0000, 0, 8'd0, 0, "cx_dime");
        step(3'b001, 4'b0000, 0, 0, 8'd15, 8'd0,  4'b0000, 4'b0000, 0, 8'd0, 0, "cx_nickel");
        step(3'b000, 4'b0100, 0, 0, 8'd15, 8'd25, 4'b0000, 4'b0000, 0, 8'd0, 0, "cx_sel2");
`ifdef VEND_CHANGE_EN
        step(3'b000, 4'b0000, 1, 0, 8'd0,  8'd0,  4'b0000, 4'b0000, 0, 8'd15, 1, "cancel");
        step(3'b010, 4'b0000, 0, 0, 8'd0,  8'd0,  4'b0000, 4'b0000, 1, 8'd15, 1, "chg_coin");
        step(3'b000, 4'b0000, 0, 1, 8'd0,  8'd0,  4'b0000, 4'b0000, 0, 8'd0,  0, "cancel_ack");
`else
        step(3'b000, 4'b0000, 1, 0, 8'd15, 8'd25, 4'b0000, 4'b0000, 0, 8'd0, 0, "cancel_ign2");
`endif
        do_reset("clr_e");

        // Coin on the affordability edge is refused while the vend proceeds.
        step(3'b010, 4'b0000, 0, 0, 8'd10, 8'd0,  4'b0000, 4'b0000, 0, 8'd0, 0, "vr_dime_a");
        step(3'b010, 4'b0000, 0, 0, 8'd20, 8'd0,  4'b0000, 4'b0000, 0, 8'd0, 0, "vr_dime_b");
        step(3'b000, 4'b0010, 0, 0, 8'd20, 8'd20, 4'b0000, 4'b0000, 0, 8'd0, 0, "vr_sel1");
        step(3'b001, 4'b0000, 0, 0, 8'd0,  8'd20, 4'b0010, 4'b0010, 1, 8'd0, 0, "vend_rej");
        step(3'b000, 4'b0000, 0, 0, 8'd0,  8'd0,  4'b0000, 4'b0010, 0, 8'd0, 0, "vr_idle");

        // clr in the middle of a transaction discards everything.
`ifdef VEND_CHANGE_EN
        step(3'b010, 4'b0000, 0, 0, 8'd10, 8'd0,  4'b0000, 4'b0000, 0, 8'd0,  0, "ab_dime");
        step(3'b000, 4'b0000, 1, 0, 8'd0,  8'd0,  4'b0000, 4'b0000, 0, 8'd10, 1, "ab_cancel");
        do_reset("clr_in_chg");
`else
        step(3'b010, 4'b0000, 0, 0, 8'd10, 8'd0,  4'b0000, 4'b0000, 0, 8'd0, 0, "ab_dime_a");
        step(3'b010, 4'b0000, 0, 0, 8'd20, 8'd0,  4'b0000, 4'b0000, 0, 8'd0, 0, "ab_dime_b");
        step(3'b000, 4'b0010, 0, 0, 8'd20, 8'd20, 4'b0000, 4'b0000, 0, 8'd0, 0, "ab_sel1");
        step(3'b000, 4'b0000, 0, 0, 8'd0,  8'd20, 4'b0010, 4'b0010, 0, 8'd0, 0, "ab_vend");
        do_reset("clr_in_vend");
`endif
        step(3'b000, 4'b0000, 0, 0, 8'd0, 8'd0, 4'b0000, 4'b0000, 0, 8'd0, 0, "post_clr");

        // Let the monitor consume the last expectation, bounded by a few edges.
        repeat (3) @(posedge clk_1Hz);
        #2;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain got %0d pending required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vend_core_param.md
# vend_core_param

Parametrised vending-machine transaction core, clocked by the 1 Hz enable-domain clock produced by the board clock divider. It accumulates coin credit from `N_COINS` denominations and tracks a selection from `N_ITEMS` products with per-item prices. It issues a one-cycle vend pulse and latched product LED, and returns change or holds the remainder. Its `credit` and `price` outputs feed the existing 4-digit seven-segment digit controller.

## Interface
Parameters:
- `W`, 8, credit/price/coin value width (binary, unsigned).
- `N_COINS`, 3, number of coin inputs.
- `COIN_VALUES`, {8'd25,8'd10,8'd5}, packed `N_COINS*W`; coin i value at `[i*W +: W]`.
- `N_ITEMS`, 4, number of products.
- `PRICES`, {8'd30,8'd25,8'd20,8'd15}, packed `N_ITEMS*W`; item i price at `[i*W +: W]`. Every price is >0 and ≤`MAX_CREDIT`.
- `MAX_CREDIT`, 35, credit ceiling; must be <2^W.

Ports:
- `clk_1Hz` in 1, state clock. Everything is on its rising edge.
- `clr` in 1, reset; asynchronous, active-high.
- `coin` in `N_COINS`, coin-inserted levels, one bit per denomination.
- `sel` in `N_ITEMS`, product select.
- `cancel` in 1, refund request.
- `change_ack` in 1, change-collected acknowledge.
- `credit` out W, current credit.
- `price` out W, price of the latched selection; 0 if no selection.
- `vend` out `N_ITEMS`, one-hot one-cycle dispense pulse.
- `led` out `N_ITEMS`, one-hot last-vended indicator.
- `coin_reject` out 1, one-cycle pulse when a coin is refused.
- `change` out W, change amount.
- `change_valid` out 1, change offered.

## Operation
- States: IDLE (credit 0), ACCUM, VEND, CHANGE.
- Coins:
  - If several `coin` bits are high, only the lowest index is taken; the others are ignored silently.
  - A coin is accepted when `credit + value ≤ MAX_CREDIT`. On acceptance, `credit` increases by the coin value and `led` clears.
  - Otherwise `coin_reject` pulses and `credit` is unchanged.
- Selection:
  - A nonzero `sel` in IDLE or ACCUM latches the lowest set bit into `sel_idx` and sets `sel_valid`.
  - A later nonzero `sel` overwrites the selection.
  - `price` is `PRICES[sel_idx]` when `sel_valid` is set, else 0.
- IDLE: an accepted coin moves to ACCUM.
- ACCUM: the following checks are evaluated each edge, in priority order.
  1. `cancel` (when the macro is enabled) → CHANGE with `change = credit`, `credit = 0`, `sel_valid = 0`.
  2. `sel_valid && credit ≥ price` → VEND. On this edge:
     - `credit` becomes `credit − price`;
     - `vend[sel_idx]` is set;
     - `led` becomes one-hot `sel_idx`;
     - any coin on this edge is rejected.
  3. Otherwise, the coin rules apply.
- VEND (one cycle): `sel_valid` clears and `vend` clears on exit. The next state depends on the remaining credit:
  - remainder 0 → IDLE;
  - remainder >0 → see Configuration.
- CHANGE:
  - `change_valid` stays high and `change` stays stable until `change_ack` is sampled high.
  - On that edge: → IDLE, `change_valid = 0`, `change = 0`.
  - Coins in CHANGE are rejected. `sel` and `cancel` are ignored.
- `cancel` in IDLE or VEND is ignored.

## Timing
- Reset value of all outputs is 0; state = IDLE, `sel_idx = 0`, `sel_valid = 0`.
- `clr` mid-operation (including CHANGE or VEND) aborts immediately. Credit is discarded, and there is no vend or change.
- All outputs are registered, except `price`, which is a combinational decode of the registered `sel_idx`/`sel_valid`.
- Coin accepted at edge k → `credit` is updated after edge k.
- `sel` is latched at edge k. The affordability check happens at edge k+1, and the `vend` pulse is high during cycle k+1→k+2.
- `vend` and `coin_reject` are exactly one `clk_1Hz` cycle wide.
- Arithmetic is unsigned W-bit. Overflow is impossible by the `MAX_CREDIT` rule, and subtraction occurs only when `credit ≥ price`.

## Configuration
- `VEND_CHANGE_EN` defined:
  - `cancel` is active.
  - A nonzero post-vend remainder goes VEND → CHANGE with `change = remainder` and `credit = 0`.
- `VEND_CHANGE_EN` undefined:
  - `cancel` is ignored, and `change`/`change_valid` are tied to 0.
  - The CHANGE state is unreachable.
  - A nonzero remainder goes VEND → ACCUM with the remainder kept as credit.

## Test plan
- Insert coin1 (10) twice, then sel=0010 → `credit` reads 10 then 20; `vend=0010` for one cycle; `credit=0`, `led=0010`, state IDLE.
- With `VEND_CHANGE_EN` defined, coin2 (25) then sel=0001 → `vend=0001`, `change=10` with `change_valid` held until `change_ack`, then IDLE.
- Same stimulus with `VEND_CHANGE_EN` undefined → `vend=0001`, `credit=10` in ACCUM, `change_valid` stays 0.
- Credit 30 plus coin1 (10) → `coin_reject` pulses, `credit` stays 30. A following coin0 (5) is accepted → `credit=35`.
- Credit 15 with sel=0100 (price 25) pending, then `cancel` (macro defined) → `change=15`, `sel_valid=0`, `price=0`, no vend.
- Credit 20 with item1 selected and coin0 on the affordability edge → `vend=0010`, `coin_reject` pulses, `credit=0`. Separately, `clr` asserted during CHANGE → all outputs 0 immediately.
